// File: rtl/phy_reset_seq.sv
// Multi-PHY reset sequencer running from the slow init clock.
// The sequence is: a common pre-delay with all lines released, a common
// hold-low window, staggered per-channel release in index order, and a
// settle window. It then reports completion (out_en low, ready high).
// A restart request is honoured only once the sequence has completed.
// Optional build macro PHY_RESET_SEQ_STATUS_EN adds the seq_cnt (accepted
// restarts, saturating) and phase (current state) status outputs.
module phy_reset_seq #(
    parameter int N_PHY       = 2,
    parameter int CNT_W       = 10,
    parameter int PRE_CYC     = 3,
    parameter int HOLD_CYC    = 100,
    parameter int STAGGER_CYC = 5,
    parameter int SETTLE_CYC  = 20
) (
    input  logic             init_clk,
    input  logic             reset,
    input  logic             restart_req,
    output logic             restart_ack,
    output logic [N_PHY-1:0] phy_reset,
    output logic             out_en,
    output logic             ready,
    output logic [N_PHY-1:0] busy_ch
`ifdef PHY_RESET_SEQ_STATUS_EN
    ,
    output logic [3:0]       seq_cnt,
    output logic [2:0]       phase
`endif
);

    // Last counter value of each phase; a zero-length phase still takes one cycle.
    localparam int PRE_LAST    = (PRE_CYC     == 0) ? 0 : PRE_CYC - 1;
    localparam int HOLD_LAST   = (HOLD_CYC    == 0) ? 0 : HOLD_CYC - 1;
    localparam int STAG_LAST   = (STAGGER_CYC == 0) ? 0 : STAGGER_CYC - 1;
    localparam int SETTLE_LAST = (SETTLE_CYC  == 0) ? 0 : SETTLE_CYC - 1;

    localparam int MAX_AB  = (PRE_CYC > HOLD_CYC) ? PRE_CYC : HOLD_CYC;
    localparam int MAX_CD  = (STAGGER_CYC > SETTLE_CYC) ? STAGGER_CYC : SETTLE_CYC;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;

    localparam int IDX_W = (N_PHY > 1) ? $clog2(N_PHY) : 1;

    // Reject configurations the counter or channel logic cannot represent.
    if (CNT_W < 1 || CNT_W > 31 || longint'(MAX_CYC) > ((64'd1 << CNT_W) - 64'd1)) begin : g_cnt_w_check
        $error("phy_reset_seq: CNT_W=%0d cannot hold phase length %0d", CNT_W, MAX_CYC);
    end
    if (HOLD_CYC < 1) begin : g_hold_check
        $error("phy_reset_seq: HOLD_CYC must be at least 1");
    end
    if (N_PHY < 1 || N_PHY > 8) begin : g_nphy_check
        $error("phy_reset_seq: N_PHY=%0d outside 1..8", N_PHY);
    end

    typedef enum logic [2:0] {
        ST_PRE     = 3'd0,
        ST_HOLD    = 3'd1,
        ST_STAGGER = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [N_PHY-1:0]   phy_reset_q, phy_reset_d;
    logic [N_PHY-1:0]   busy_ch_q, busy_ch_d;
    logic               out_en_q, out_en_d;
    logic               ready_q, ready_d;
    logic               ack_q, ack_d;

    // State and output registers; reset releases every PHY line at once.
    always_ff @(posedge init_clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_PRE;
            cnt_q       <= '0;
            idx_q       <= '0;
            phy_reset_q <= '1;
            busy_ch_q   <= '0;
            out_en_q    <= 1'b1;
            ready_q     <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            phy_reset_q <= phy_reset_d;
            busy_ch_q   <= busy_ch_d;
            out_en_q    <= out_en_d;
            ready_q     <= ready_d;
            ack_q       <= ack_d;
        end
    end

    // Next-state logic: each phase counts up to its last value, then clears the counter and advances.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        phy_reset_d = phy_reset_q;
        busy_ch_d   = busy_ch_q;
        out_en_d    = out_en_q;
        ready_d     = ready_q;
        ack_d       = 1'b0;

        case (state_q)
            ST_PRE: begin
                if (cnt_q == CNT_W'(PRE_LAST)) begin
                    state_d     = ST_HOLD;
                    cnt_d       = '0;
                    phy_reset_d = '0;
                    busy_ch_d   = '1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == CNT_W'(HOLD_LAST)) begin
                    cnt_d          = '0;
                    phy_reset_d[0] = 1'b1;
                    busy_ch_d[0]   = 1'b0;
                    idx_d          = IDX_W'(1);
                    state_d        = (N_PHY > 1) ? ST_STAGGER : ST_SETTLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STAGGER: begin
                if (cnt_q == CNT_W'(STAG_LAST)) begin
                    cnt_d              = '0;
                    phy_reset_d[idx_q] = 1'b1;
                    busy_ch_d[idx_q]   = 1'b0;
                    if (idx_q == IDX_W'(N_PHY - 1)) begin
                        state_d = ST_SETTLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_LAST)) begin
                    state_d  = ST_DONE;
                    cnt_d    = '0;
                    out_en_d = 1'b0;
                    ready_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                // Lines stay released; the new sequence re-asserts them at the end of PRE.
                if (restart_req) begin
                    ack_d    = 1'b1;
                    state_d  = ST_PRE;
                    cnt_d    = '0;
                    idx_d    = '0;
                    out_en_d = 1'b1;
                    ready_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_PRE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    assign restart_ack = ack_q;
    assign phy_reset   = phy_reset_q;
    assign busy_ch     = busy_ch_q;
    assign out_en      = out_en_q;
    assign ready       = ready_q;

`ifdef PHY_RESET_SEQ_STATUS_EN
    logic [3:0] seq_cnt_q, seq_cnt_d;

    // Accepted-restart counter saturates at 15.
    always_comb begin
        seq_cnt_d = seq_cnt_q;
        if (ack_d && (seq_cnt_q != 4'hF)) begin
            seq_cnt_d = seq_cnt_q + 4'd1;
        end
    end

    // Restart counter register, cleared only by reset.
    always_ff @(posedge init_clk or posedge reset) begin
        if (reset) begin
            seq_cnt_q <= '0;
        end else begin
            seq_cnt_q <= seq_cnt_d;
        end
    end

    assign seq_cnt = seq_cnt_q;
    assign phase   = state_q;
`endif

endmodule

// File: doc/phy_reset_seq.md
Name: phy_reset_seq

Overview:
- Parametrised multi-PHY reset sequencer clocked from the slow init clock (10 kHz nominal).
- Drives N_PHY active-low PHY reset lines: a common pre-delay, a common hold-low window, then staggered per-channel release and a settle window.
- Flags completion to the MAC/FIFO logic (out_en, ready).
- Accepts a software restart request with a single-cycle acknowledge.

Parameters:
- N_PHY, 2, number of PHY reset channels (1..8)
- CNT_W, 10, width of the internal phase counter
- PRE_CYC, 3, init_clk cycles with all resets deasserted before assertion
- HOLD_CYC, 100, cycles all resets are held low (100 = 10 ms at 10 kHz)
- STAGGER_CYC, 5, cycles between release of channel k and channel k+1
- SETTLE_CYC, 20, cycles after the last release before ready

Ports:
- init_clk  in  1  sequencer clock, rising edge
- reset  in  1  asynchronous, active-high
- restart_req  in  1  request a new sequence; sampled only in DONE
- restart_ack  out  1  one-cycle pulse when a restart is accepted
- phy_reset  out  N_PHY  per-PHY reset, active-low (0 = PHY held in reset)
- out_en  out  1  high while a sequence is in progress
- ready  out  1  high in DONE only
- busy_ch  out  N_PHY  bit k high while PHY k is still held in reset

Behaviour:
- Reset values:
  - state = PRE, counter = 0, channel index = 0.
  - phy_reset = all 1, out_en = 1, ready = 0, restart_ack = 0, busy_ch = all 0.
- Timing reference: edge n = the n-th rising edge after reset deasserts, counting from 0. All outputs are registered.
- PRE: lasts PRE_CYC cycles.
  - At edge PRE_CYC-1, go to HOLD and drive phy_reset = all 0, busy_ch = all 1.
- HOLD: lasts HOLD_CYC cycles.
  - At its last edge, release channel 0 (phy_reset[0]=1, busy_ch[0]=0).
  - If N_PHY>1 go to STAGGER, else go to SETTLE.
- STAGGER: every STAGGER_CYC cycles release the next channel in index order.
  - After releasing channel N_PHY-1, go to SETTLE.
- SETTLE: lasts SETTLE_CYC cycles, then go to DONE with out_en=0, ready=1.
- Total time from reset release to ready = PRE_CYC + HOLD_CYC + (N_PHY-1)*STAGGER_CYC + SETTLE_CYC cycles.
- DONE:
  - restart_req=1 → restart_ack=1 for exactly one cycle; state PRE, counter 0, out_en=1, ready=0.
  - Lines already high stay high through PRE.
- restart_req outside DONE is ignored: no ack, sequence unaffected. It is not latched; the requester must hold it until acked.
- A level-held restart_req produces one restart per completed sequence.
- Asynchronous reset at any point returns to reset values immediately. phy_reset is released to all 1 at once, then the full sequence reruns.
- Zero-length phases (PRE_CYC, STAGGER_CYC, SETTLE_CYC = 0) collapse to one cycle. HOLD_CYC must be ≥1.
- Elaboration check: CNT_W must hold max(PRE_CYC, HOLD_CYC, STAGGER_CYC, SETTLE_CYC). Fail elaboration otherwise.
- The counter never wraps. It clears on every phase transition.

Optional Feature:
- Macro: PHY_RESET_SEQ_STATUS_EN.
- With it defined:
  - Extra output seq_cnt (4 bits): saturating count of accepted restarts; cleared by reset, sticks at 15.
  - Extra output phase (3 bits), encoding PRE=0, HOLD=1, STAGGER=2, SETTLE=3, DONE=4.
- Without it: neither port exists, and there is no associated logic.

Test Plan (defaults: N_PHY=2, PRE=3, HOLD=100, STAGGER=5, SETTLE=20):
- Reset release → phy_reset=2'b11 after edges 0..2, 2'b00 after edge 2; phy_reset[0] rises after edge 102, phy_reset[1] after edge 107; out_en falls and ready rises after edge 127.
- restart_req pulsed at edge 50 (HOLD) → no restart_ack; timing identical to the previous test.
- restart_req held high in DONE → restart_ack high for exactly one cycle; ready=0; phy_reset goes 2'b00 three cycles later; the sequence completes again 128 cycles after the ack.
- Async reset asserted at edge 60 for half a cycle → phy_reset=2'b11 immediately, out_en=1, ready=0; the sequence restarts from edge 0 timing.
- N_PHY=4, STAGGER=0 → channels release on consecutive cycles 102..105; ready after edge 125.
- With PHY_RESET_SEQ_STATUS_EN, 17 restarts → seq_cnt=15; phase=4 in DONE, phase=1 during hold.
